// File: rtl/wb_regfile.sv
// Writeback register file: 15x64 regs, two write ports, two read ports.
// Tracks program status, a sticky halt flag, and retire/cycle counters.
module wb_regfile (
  input  logic               clk,
  input  logic               rst,
  input  logic        [1:0]  W_stat,
  input  logic        [3:0]  W_icode,
  input  logic        [3:0]  W_dstE,
  input  logic        [3:0]  W_dstM,
  input  logic signed [63:0] W_valE,
  input  logic signed [63:0] W_valM,
  input  logic               W_stall,
  input  logic        [3:0]  d_srcA,
  input  logic        [3:0]  d_srcB,
  output logic        [63:0] d_rvalA,
  output logic        [63:0] d_rvalB,
  output logic        [1:0]  prog_stat,
  output logic               halted,
  output logic        [31:0] retired_cnt,
  output logic        [31:0] cycle_cnt
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [1:0] S_AOK  = 2'd0;
  localparam logic [3:0] I_NOP  = 4'd1;

  logic [63:0] regs [15];

  logic live;
  logic commit;
  logic halt_now;
  logic we_e;
  logic we_m;
  logic retire;

  assign live     = !W_stall && !halted;
  assign commit   = live && (W_stat == S_AOK);
  assign halt_now = live && (W_stat != S_AOK);
  assign we_e     = commit && (W_dstE != RNONE);
  assign we_m     = commit && (W_dstM != RNONE);
  assign retire   = commit && (W_icode != I_NOP);

  // M port wins a same-register collision (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (we_m && (W_dstM == 4'(i)))
          regs[i] <= W_valM;
        else if (we_e && (W_dstE == 4'(i)))
          regs[i] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_stat <= S_AOK;
      halted    <= 1'b0;
    end else if (halt_now) begin
      prog_stat <= W_stat;
      halted    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      cycle_cnt   <= '0;
    end else begin
      if (retire)
        retired_cnt <= retired_cnt + 32'd1;
      if (!halted)
        cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    if (d_srcA != RNONE)
      d_rvalA = regs[d_srcA];
    if (d_srcB != RNONE)
      d_rvalB = regs[d_srcB];
  end

endmodule
